// File: rtl/id_issue_ctrl_pkg.sv
// Shared pipeline definitions for the decode-stage issue controller:
// forward-select encodings, pipeline shadow tags and muldiv latency defaults.
package cpu_defs;

  localparam int REG_W = 5;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_EX  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam int MUL_CYCLES_DEF = 4;
  localparam int DIV_CYCLES_DEF = 32;

  typedef struct packed {
    logic             v;
    logic [REG_W-1:0] wreg;
    logic             we;
    logic             ld;
  } tag_t;

  // Register $0 is hardwired, so it never produces a hazard or a forward.
  function automatic logic tag_match(input tag_t t, input logic [REG_W-1:0] src);
    return t.v & t.we & (t.wreg == src) & (src != '0);
  endfunction

endpackage

// File: rtl/id_issue_ctrl_md_counter.sv
// Busy counter for the multi-cycle HI/LO multiply/divide unit.
module md_counter #(
  parameter int unsigned MUL_CYCLES = 4,
  parameter int unsigned DIV_CYCLES = 32,
  parameter int unsigned CNT_W      = 6
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic is_div,
  output logic busy
);

  localparam logic [CNT_W-1:0] MUL_V = CNT_W'(MUL_CYCLES);
  localparam logic [CNT_W-1:0] DIV_V = CNT_W'(DIV_CYCLES);

  logic [CNT_W-1:0] md_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      md_cnt <= '0;
    end else if (load) begin
      md_cnt <= is_div ? DIV_V : MUL_V;
    end else if (md_cnt != '0) begin
      md_cnt <= md_cnt - CNT_W'(1);
    end
  end

  assign busy = (md_cnt != '0);

endmodule

// File: rtl/id_issue_ctrl.sv
// Decode-stage issue/hazard controller: load-use and HI/LO stalls, flush,
// operand forwarding selects and EX/MEM shadow tags.
module id_issue_ctrl
  import cpu_defs::*;
#(
  parameter int unsigned MUL_CYCLES = MUL_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES = DIV_CYCLES_DEF,
  parameter int unsigned CNT_W      = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [REG_W-1:0] rs,
  input  logic [REG_W-1:0] rt,
  input  logic             use_rs,
  input  logic             use_rt,
  input  logic [REG_W-1:0] wreg,
  input  logic             reg_write,
  input  logic             is_load,
  input  logic             md_start,
  input  logic             md_is_div,
  input  logic             hilo_read,
  input  logic             flush,
  output logic             issue,
  output logic             stall,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             md_busy
);

  // Handshake: id_valid offers an instruction; it is taken in the cycle that
  // issue=1. stall=1 holds it in ID; flush=1 discards it without a stall.
  tag_t ex_tag;
  tag_t mem_tag;
  logic load_use;
  logic md_hazard;

  function automatic logic [1:0] fwd_sel(input logic use_src, input logic [REG_W-1:0] src,
                                         input tag_t ex_t, input tag_t mem_t);
    if (use_src && tag_match(ex_t, src) && !ex_t.ld) begin
      return FWD_EX;
    end else if (use_src && tag_match(mem_t, src)) begin
      return FWD_MEM;
    end else begin
      return FWD_RF;
    end
  endfunction

  always_comb begin
    load_use  = id_valid &
                ((use_rs & tag_match(ex_tag, rs) & ex_tag.ld) |
                 (use_rt & tag_match(ex_tag, rt) & ex_tag.ld));
    md_hazard = id_valid & (md_start | hilo_read) & md_busy;
  end

  assign stall = ~flush & (load_use | md_hazard);
  assign issue = id_valid & ~flush & ~stall;
  assign fwd_a = fwd_sel(use_rs, rs, ex_tag, mem_tag);
  assign fwd_b = fwd_sel(use_rt, rt, ex_tag, mem_tag);

  // EX never stalls, so MEM always takes what EX held; non-issue injects a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_tag  <= '0;
      mem_tag <= '0;
    end else begin
      mem_tag <= ex_tag;
      if (issue) begin
        ex_tag <= '{v: 1'b1, wreg: wreg, we: reg_write, ld: is_load};
      end else begin
        ex_tag <= '0;
      end
    end
  end

  md_counter #(
    .MUL_CYCLES (MUL_CYCLES),
    .DIV_CYCLES (DIV_CYCLES),
    .CNT_W      (CNT_W)
  ) u_md_counter (
    .clk    (clk),
    .rst    (rst),
    .load   (issue & md_start),
    .is_div (md_is_div),
    .busy   (md_busy)
  );

endmodule

// File: tb/tb_id_issue_ctrl.sv
// Directed bench for id_issue_ctrl: a per-cycle vector table for the
// forwarding/hazard paths plus hand sequences for muldiv and reset.
module tb_id_issue_ctrl;

  logic       clk;
  logic       rst;
  logic       id_valid;
  logic [4:0] rs, rt, wreg;
  logic       use_rs, use_rt, reg_write, is_load;
  logic       md_start, md_is_div, hilo_read, flush;
  logic       issue, stall, md_busy;
  logic [1:0] fwd_a, fwd_b;

  int n_cmp;
  int n_err;

  typedef struct {
    string      name;
    logic       v;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       urs;
    logic       urt;
    logic [4:0] wreg;
    logic       rw;
    logic       ld;
    logic       fl;
    logic       e_issue;
    logic       e_stall;
    logic [1:0] e_fa;
    logic [1:0] e_fb;
  } vec_t;

  vec_t tbl[$];
  logic [2:0] exp_q[$];

  id_issue_ctrl #(
    .MUL_CYCLES (4),
    .DIV_CYCLES (32),
    .CNT_W      (6)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .id_valid  (id_valid),
    .rs        (rs),
    .rt        (rt),
    .use_rs    (use_rs),
    .use_rt    (use_rt),
    .wreg      (wreg),
    .reg_write (reg_write),
    .is_load   (is_load),
    .md_start  (md_start),
    .md_is_div (md_is_div),
    .hilo_read (hilo_read),
    .flush     (flush),
    .issue     (issue),
    .stall     (stall),
    .fwd_a     (fwd_a),
    .fwd_b     (fwd_b),
    .md_busy   (md_busy)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(string n, logic v, logic [4:0] s, logic [4:0] t, logic urs,
                              logic urt, logic [4:0] d, logic rw, logic ld, logic fl,
                              logic ei, logic es, logic [1:0] fa, logic [1:0] fb);
    vec_t r;
    r.name = n; r.v = v; r.rs = s; r.rt = t; r.urs = urs; r.urt = urt;
    r.wreg = d; r.rw = rw; r.ld = ld; r.fl = fl;
    r.e_issue = ei; r.e_stall = es; r.e_fa = fa; r.e_fb = fb;
    return r;
  endfunction

  task automatic drive(input logic v, input logic [4:0] s, input logic [4:0] t,
                       input logic urs, input logic urt, input logic [4:0] d,
                       input logic rw, input logic ld, input logic mds, input logic mdd,
                       input logic hr, input logic fl);
    id_valid = v; rs = s; rt = t; use_rs = urs; use_rt = urt; wreg = d;
    reg_write = rw; is_load = ld; md_start = mds; md_is_div = mdd;
    hilo_read = hr; flush = fl;
  endtask

  task automatic chk(input string name, input logic [1:0] got, input logic [1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // Inputs change 1ns after the rising edge; outputs are sampled 4ns later.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    tbl.push_back(mk("reset_idle",      0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00));
    tbl.push_back(mk("addu3_1_2",       1, 1, 2, 1, 1, 3, 1, 0, 0, 1, 0, 2'b00, 2'b00));
    tbl.push_back(mk("addu4_3_3_ex",    1, 3, 3, 1, 1, 4, 1, 0, 0, 1, 0, 2'b01, 2'b01));
    tbl.push_back(mk("addu5_3_0_mem",   1, 3, 0, 1, 1, 5, 1, 0, 0, 1, 0, 2'b10, 2'b00));
    tbl.push_back(mk("lw6_base3",       1, 3, 6, 1, 0, 6, 1, 1, 0, 1, 0, 2'b00, 2'b00));
    tbl.push_back(mk("load_use_stall",  1, 1, 6, 1, 1, 7, 1, 0, 0, 0, 1, 2'b00, 2'b00));
    tbl.push_back(mk("load_use_issue",  1, 1, 6, 1, 1, 7, 1, 0, 0, 1, 0, 2'b00, 2'b10));
    tbl.push_back(mk("after_bubble",    1, 6, 7, 1, 1, 8, 1, 0, 0, 1, 0, 2'b00, 2'b01));
    tbl.push_back(mk("lw_r0",           1, 1, 0, 1, 0, 0, 1, 1, 0, 1, 0, 2'b00, 2'b00));
    tbl.push_back(mk("read_r0",         1, 0, 0, 1, 1, 9, 1, 0, 0, 1, 0, 2'b00, 2'b00));
    tbl.push_back(mk("lw10",            1, 1, 0, 1, 0, 10, 1, 1, 0, 1, 0, 2'b00, 2'b00));
    tbl.push_back(mk("flush_over_lu",   1, 10, 0, 1, 0, 11, 1, 0, 1, 0, 0, 2'b00, 2'b00));
    tbl.push_back(mk("after_flush",     1, 10, 0, 1, 0, 11, 1, 0, 0, 1, 0, 2'b10, 2'b00));
    tbl.push_back(mk("fwd_when_idle",   0, 11, 0, 1, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00));
    tbl.push_back(mk("mem_after_idle",  1, 11, 0, 1, 0, 0, 0, 0, 0, 1, 0, 2'b10, 2'b00));
    tbl.push_back(mk("w12_a",           1, 0, 0, 0, 0, 12, 1, 0, 0, 1, 0, 2'b00, 2'b00));
    tbl.push_back(mk("w12_b",           1, 0, 0, 0, 0, 12, 1, 0, 0, 1, 0, 2'b00, 2'b00));
    tbl.push_back(mk("ex_over_mem",     1, 12, 12, 1, 1, 0, 0, 0, 0, 1, 0, 2'b01, 2'b01));
    tbl.push_back(mk("no_we_13",        1, 0, 0, 0, 0, 13, 0, 0, 0, 1, 0, 2'b00, 2'b00));
    tbl.push_back(mk("read_no_we",      1, 13, 13, 1, 1, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00));

    foreach (tbl[i]) begin
      drive(tbl[i].v, tbl[i].rs, tbl[i].rt, tbl[i].urs, tbl[i].urt, tbl[i].wreg,
            tbl[i].rw, tbl[i].ld, 0, 0, 0, tbl[i].fl);
      #4;
      chk({tbl[i].name, ".issue"}, {1'b0, issue}, {1'b0, tbl[i].e_issue});
      chk({tbl[i].name, ".stall"}, {1'b0, stall}, {1'b0, tbl[i].e_stall});
      chk({tbl[i].name, ".fwd_a"}, fwd_a, tbl[i].e_fa);
      chk({tbl[i].name, ".fwd_b"}, fwd_b, tbl[i].e_fb);
      chk({tbl[i].name, ".md_busy"}, {1'b0, md_busy}, 2'b00);
      next_cycle();
    end

    // Divide: issue, then mfhi waits 32 cycles and issues on the 33rd.
    drive(1, 1, 2, 1, 1, 0, 0, 0, 1, 1, 0, 0);
    #4;
    chk("div.issue", {1'b0, issue}, 2'b01);
    chk("div.busy_pre", {1'b0, md_busy}, 2'b00);
    next_cycle();
    for (int i = 0; i < 32; i++) exp_q.push_back(3'b011);
    exp_q.push_back(3'b100);
    drive(1, 0, 0, 0, 0, 14, 1, 0, 0, 0, 1, 0);
    for (int c = 0; c < 33; c++) begin
      logic [2:0] e;
      e = exp_q.pop_front();
      #4;
      n_cmp++;
      if ({issue, stall, md_busy} !== e) begin
        n_err++;
        $display("FAIL mfhi_wait cyc%0d: {issue,stall,busy} got %b, expected %b",
                 c + 1, {issue, stall, md_busy}, e);
      end
      next_cycle();
    end

    // Mult, then lw, then a dependent mult: load-use and md hazards overlap.
    drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    #4;
    chk("mult1.issue", {1'b0, issue}, 2'b01);
    next_cycle();
    drive(1, 1, 0, 1, 0, 15, 1, 1, 0, 0, 0, 0);
    #4;
    chk("lw15.issue", {1'b0, issue}, 2'b01);
    chk("lw15.busy", {1'b0, md_busy}, 2'b01);
    next_cycle();
    drive(1, 15, 2, 1, 1, 0, 0, 0, 1, 0, 0, 0);
    for (int c = 0; c < 3; c++) begin
      #4;
      chk($sformatf("mult2_hold%0d.stall", c), {1'b0, stall}, 2'b01);
      chk($sformatf("mult2_hold%0d.issue", c), {1'b0, issue}, 2'b00);
      next_cycle();
    end
    #4;
    chk("mult2.issue", {1'b0, issue}, 2'b01);
    chk("mult2.fwd_a", fwd_a, 2'b00);
    next_cycle();

    // Reset while the second mult still counts (cnt=3 in the reset cycle).
    drive(1, 0, 0, 0, 0, 16, 1, 0, 0, 0, 0, 0);
    #4;
    chk("addu16.issue", {1'b0, issue}, 2'b01);
    next_cycle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    #4;
    chk("rst_cycle.busy", {1'b0, md_busy}, 2'b01);
    next_cycle();
    rst = 1'b0;
    drive(1, 16, 16, 1, 1, 17, 1, 0, 0, 0, 1, 0);
    #4;
    chk("post_rst.busy", {1'b0, md_busy}, 2'b00);
    chk("post_rst.issue", {1'b0, issue}, 2'b01);
    chk("post_rst.stall", {1'b0, stall}, 2'b00);
    chk("post_rst.fwd_a", fwd_a, 2'b00);
    chk("post_rst.fwd_b", fwd_b, 2'b00);
    next_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
